// File: rtl/cdb_arbiter_pkg.sv
// Shared back-end types for the common-data-bus arbiter: ROB tag, physical RF address/data and
// the CDB entry carried by holding and output registers.
package cdb_arbiter_pkg;

  localparam int unsigned RobDepth   = 32;
  localparam int unsigned RobAddrW   = $clog2(RobDepth);
  localparam int unsigned PhyRfAddrW = 6;
  localparam int unsigned PhyRfDataW = 32;

  typedef logic [RobAddrW-1:0]   rob_addr_t;
  typedef logic [PhyRfAddrW-1:0] phy_rf_addr_t;
  typedef logic [PhyRfDataW-1:0] phy_rf_data_t;

  typedef struct packed {
    rob_addr_t    rob_addr;
    phy_rf_addr_t dest;
    phy_rf_data_t value;
  } cdb_entry_t;

  // Distance from the ROB head; relies on RobDepth being a power of two for the wrap.
  function automatic rob_addr_t rob_age(rob_addr_t addr, rob_addr_t head);
    return addr - head;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Rotating-priority one-hot picker: ptr_i names the highest-priority request, search wraps upward.
module cdb_rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PtrW'((32'(ptr_i) + off) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit holding registers, one grant per cycle onto a registered CDB.
// Define QU_CDB_OLDEST_FIRST_EN to grant the oldest ROB entry instead of round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  rob_addr_t                  rob_head_ptr_i,
  input  logic         [NUM_REQ-1:0] req_valid_i,
  output logic         [NUM_REQ-1:0] req_ready_o,
  input  rob_addr_t    [NUM_REQ-1:0] req_rob_addr_i,
  input  phy_rf_addr_t [NUM_REQ-1:0] req_dest_i,
  input  phy_rf_data_t [NUM_REQ-1:0] req_value_i,
  output logic                       res_st_retire_en_o,
  output rob_addr_t                  res_st_retire_rob_addr_o,
  output phy_rf_data_t               res_st_retire_value_o,
  output logic                       phy_rf_wr_en_o,
  output phy_rf_addr_t               phy_rf_wr_addr_o,
  output phy_rf_data_t               phy_rf_wr_data_o,
  output logic                       busy_table_wr_en_o,
  output phy_rf_addr_t               busy_table_wr_addr_o,
  output logic                       busy_table_wr_data_o
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic       [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  cdb_entry_t [NUM_REQ-1:0] hold_q, hold_d;
  cdb_entry_t               out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic       [NUM_REQ-1:0] grant;
  logic       [PtrW-1:0]    gnt_idx;

`ifdef QU_CDB_OLDEST_FIRST_EN
  logic            best_found;
  rob_addr_t       best_age;
  logic [PtrW-1:0] best_idx;

  always_comb begin
    grant      = '0;
    best_found = 1'b0;
    best_age   = '1;
    best_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hold_valid_q[i] &&
          (!best_found || rob_age(hold_q[i].rob_addr, rob_head_ptr_i) < best_age)) begin
        best_found = 1'b1;
        best_age   = rob_age(hold_q[i].rob_addr, rob_head_ptr_i);
        best_idx   = PtrW'(i);
      end
    end
    if (best_found) grant[best_idx] = 1'b1;
  end
`else
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            unused_rob_head;

  assign unused_rob_head = ^rob_head_ptr_i;

  cdb_rr_picker #(
    .N(NUM_REQ)
  ) u_rr_picker (
    .req_i(hold_valid_q),
    .ptr_i(rr_ptr_q),
    .gnt_o(grant)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant && !flush_i) begin
      rr_ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = PtrW'(i);
    end
  end

  // A granted entry frees its slot in the same cycle, so a unit can stream back-to-back.
  assign req_ready_o = ~hold_valid_q | grant;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (flush_i) begin
        hold_valid_d[i] = 1'b0;
      end else if (req_valid_i[i] && req_ready_o[i]) begin
        hold_valid_d[i]    = 1'b1;
        hold_d[i].rob_addr = req_rob_addr_i[i];
        hold_d[i].dest     = req_dest_i[i];
        hold_d[i].value    = req_value_i[i];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d = |grant && !flush_i;
    out_d       = (|grant) ? hold_q[gnt_idx] : out_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign res_st_retire_en_o       = out_valid_q;
  assign res_st_retire_rob_addr_o = out_q.rob_addr;
  assign res_st_retire_value_o    = out_q.value;
  // Physical register 0 is hardwired; it still retires and clears its busy bit.
  assign phy_rf_wr_en_o           = out_valid_q && (out_q.dest != '0);
  assign phy_rf_wr_addr_o         = out_q.dest;
  assign phy_rf_wr_data_o         = out_q.value;
  assign busy_table_wr_en_o       = out_valid_q;
  assign busy_table_wr_addr_o     = out_q.dest;
  assign busy_table_wr_data_o     = 1'b0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected CDB results, including their cycle, are queued at
// stimulus time and checked as the CDB fires. Honours QU_CDB_OLDEST_FIRST_EN like the RTL.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NumReq = 4;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  rob_addr_t                  rob_head;
  logic         [NumReq-1:0]  req_valid;
  logic         [NumReq-1:0]  req_ready;
  rob_addr_t    [NumReq-1:0]  req_rob;
  phy_rf_addr_t [NumReq-1:0]  req_dest;
  phy_rf_data_t [NumReq-1:0]  req_value;
  logic                       retire_en;
  rob_addr_t                  retire_rob;
  phy_rf_data_t               retire_value;
  logic                       wr_en;
  phy_rf_addr_t               wr_addr;
  phy_rf_data_t               wr_data;
  logic                       busy_en;
  phy_rf_addr_t               busy_addr;
  logic                       busy_data;

  cdb_arbiter #(
    .NUM_REQ(NumReq)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .flush_i                 (flush),
    .rob_head_ptr_i          (rob_head),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req_rob_addr_i          (req_rob),
    .req_dest_i              (req_dest),
    .req_value_i             (req_value),
    .res_st_retire_en_o      (retire_en),
    .res_st_retire_rob_addr_o(retire_rob),
    .res_st_retire_value_o   (retire_value),
    .phy_rf_wr_en_o          (wr_en),
    .phy_rf_wr_addr_o        (wr_addr),
    .phy_rf_wr_data_o        (wr_data),
    .busy_table_wr_en_o      (busy_en),
    .busy_table_wr_addr_o    (busy_addr),
    .busy_table_wr_data_o    (busy_data)
  );

  typedef struct {
    rob_addr_t    rob;
    phy_rf_addr_t dest;
    phy_rf_data_t val;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge before the handshake edge; k = cycles spent waiting behind other grants.
  task automatic push(input rob_addr_t rob, input phy_rf_addr_t dest, input phy_rf_data_t val,
                      input int k);
    exp_t e;
    e.rob  = rob;
    e.dest = dest;
    e.val  = val;
    e.cyc  = cyc + 2 + k;
    sb.push_back(e);
  endtask

  task automatic offer(input logic [1:0] u, input rob_addr_t rob, input phy_rf_addr_t dest,
                       input phy_rf_data_t val);
    req_valid[u] = 1'b1;
    req_rob[u]   = rob;
    req_dest[u]  = dest;
    req_value[u] = val;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    flush     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && (retire_en || busy_en || wr_en)) begin
      if (sb.size() == 0) begin
        check_eq("spurious_cdb", 64'(retire_en | busy_en | wr_en), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("cdb_cycle", 64'(cyc), 64'(mon_e.cyc));
        check_eq("retire_en", 64'(retire_en), 64'd1);
        check_eq("retire_rob", 64'(retire_rob), 64'(mon_e.rob));
        check_eq("retire_value", 64'(retire_value), 64'(mon_e.val));
        check_eq("busy_en", 64'(busy_en), 64'd1);
        check_eq("busy_addr", 64'(busy_addr), 64'(mon_e.dest));
        check_eq("busy_data", 64'(busy_data), 64'd0);
        check_eq("wr_en", 64'(wr_en), 64'(mon_e.dest != '0));
        if (mon_e.dest != '0) begin
          check_eq("wr_addr", 64'(wr_addr), 64'(mon_e.dest));
          check_eq("wr_data", 64'(wr_data), 64'(mon_e.val));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    rob_head  = '0;
    req_valid = '0;
    req_rob   = '0;
    req_dest  = '0;
    req_value = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_retire_en", 64'(retire_en), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_busy_en", 64'(busy_en), 64'd0);
    check_eq("rst_outputs", 64'({retire_rob, retire_value, wr_addr}), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 64'(req_ready), 64'hf);
    mon_en = 1'b1;

    // Lone request, 2-cycle latency.
    offer(2'd0, 5'd0, 6'd4, 32'd11);
    check_eq("s1_ready0", 64'(req_ready[0]), 64'd1);
    push(5'd0, 6'd4, 32'd11, 0);
    tick();
    check_eq("s1_ready0_after", 64'(req_ready[0]), 64'd1);
    repeat (3) tick();

    // Mid-operation reset drops pending results.
    offer(2'd0, 5'd9, 6'd9, 32'd99);
    offer(2'd1, 5'd10, 6'd10, 32'd100);
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_ready", 64'(req_ready), 64'hf);
    check_eq("mid_rst_retire_en", 64'(retire_en), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // All four units at once, fresh from reset.
    offer(2'd0, 5'd0, 6'd5, 32'd11);
    offer(2'd1, 5'd1, 6'd6, 32'd21);
    offer(2'd2, 5'd2, 6'd7, 32'd31);
    offer(2'd3, 5'd3, 6'd8, 32'd41);
    for (int k = 0; k < 4; k++) push(5'(k), 6'(5 + k), 32'(11 + 10 * k), k);
    repeat (6) tick();
    offer(2'd1, 5'd4, 6'd12, 32'd51);
    push(5'd4, 6'd12, 32'd51, 0);
    repeat (3) tick();

    // Unit 2 streaming every cycle.
    for (int i = 0; i < 6; i++) begin
      offer(2'd2, 5'(8 + i), 6'(20 + i), 32'(200 + i));
      check_eq("stream_ready2", 64'(req_ready[2]), 64'd1);
      push(5'(8 + i), 6'(20 + i), 32'(200 + i), 0);
      tick();
    end
    repeat (3) tick();

    // Destination p0: retire and busy clear, no RF write.
    offer(2'd3, 5'd15, 6'd0, 32'h0bad);
    push(5'd15, 6'd0, 32'h0bad, 0);
    repeat (4) tick();

    // Three pending plus a handshake, then flush.
    offer(2'd1, 5'd16, 6'd30, 32'd1);
    offer(2'd2, 5'd17, 6'd31, 32'd2);
    offer(2'd3, 5'd18, 6'd32, 32'd3);
    tick();
    flush = 1'b1;
    offer(2'd0, 5'd19, 6'd33, 32'd4);
    tick();
    check_eq("flush_ready", 64'(req_ready), 64'hf);
    repeat (3) tick();
    offer(2'd1, 5'd20, 6'd34, 32'd77);
    push(5'd20, 6'd34, 32'd77, 0);
    repeat (4) tick();

`ifdef QU_CDB_OLDEST_FIRST_EN
    // Oldest first relative to the ROB head, including a wrapped tag.
    rob_head = 5'd2;
    offer(2'd0, 5'd1, 6'd40, 32'd101);
    offer(2'd1, 5'd3, 6'd41, 32'd103);
    offer(2'd2, 5'd2, 6'd42, 32'd102);
    push(5'd2, 6'd42, 32'd102, 0);
    push(5'd3, 6'd41, 32'd103, 1);
    push(5'd1, 6'd40, 32'd101, 2);
`else
    // Pointer sits at 2 after the last unit-1 grant: search 3, wrap to 0, then 1.
    offer(2'd0, 5'd21, 6'd40, 32'd101);
    offer(2'd1, 5'd22, 6'd41, 32'd102);
    offer(2'd3, 5'd23, 6'd43, 32'd103);
    push(5'd23, 6'd43, 32'd103, 0);
    push(5'd21, 6'd40, 32'd101, 1);
    push(5'd22, 6'd41, 32'd102, 2);
`endif
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
